// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the DE0 push-buttons, the
// start key and the countdown-range slide switches for the bomb controller.
// Keys are delivered as single-cycle press pulses, and switches as clean levels.
// Optional build macro INPUT_CONDITIONER_LOCKOUT_EN: when several buttons are
// involved, at most one button pulse is allowed, and the highest index wins.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter int ACTIVE_LOW_KEYS = 1
) (
    input  logic       async_reset,
    input  logic       clk,
    input  logic [2:0] raw_buttons,
    input  logic       raw_start,
    input  logic [2:0] raw_switches,
    output logic [2:0] buttons,
    output logic       start_trigger,
    output logic [2:0] switches,
    output logic [2:0] buttons_level
);

    // Channel map: [2:0] buttons, [3] start, [6:4] switches
    localparam int NCH = 7;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [3:0]                      keyIn;
    logic [NCH-1:0]                  rawVec;
    logic [NCH-1:0]                  s1_q;
    logic [NCH-1:0]                  s2_q;
    logic [NCH-1:0]                  stable_q;
    logic [NCH-1:0]                  stable_d;
    logic [NCH-1:0][CNT_WIDTH-1:0]   cnt_q;
    logic [NCH-1:0][CNT_WIDTH-1:0]   cnt_d;
    logic [3:0]                      prev_q;
    logic [3:0]                      pulse_q;
    logic [3:0]                      pulse_d;
    logic [3:0]                      rise;
`ifdef INPUT_CONDITIONER_LOCKOUT_EN
    logic [2:0]                      allow;
`endif

    // Keys are normalised to pressed = 1 before they enter the synchroniser,
    // so a reset value of 0 means "not pressed" for every channel.
    assign keyIn  = (ACTIVE_LOW_KEYS != 0) ? ~{raw_start, raw_buttons}
                                           :  {raw_start, raw_buttons};
    assign rawVec = {raw_switches, keyIn};

    // Debounce rule: a mismatch must persist DEBOUNCE_CYCLES cycles; any agreement restarts the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Press pulses come from 0->1 transitions of the debounced key levels
    always_comb begin
        rise    = stable_q[3:0] & ~prev_q;
        pulse_d = rise;
`ifdef INPUT_CONDITIONER_LOCKOUT_EN
        allow = 3'b111;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (j > i && stable_q[j]) begin
                    allow[i] = 1'b0;
                end else if (j < i && stable_q[j] && !rise[j]) begin
                    allow[i] = 1'b0;
                end
            end
        end
        pulse_d[2:0] = rise[2:0] & allow;
`endif
    end

    // Synchronisers, debounce state and pulse registers
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            pulse_q  <= '0;
        end else begin
            s1_q     <= rawVec;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            prev_q   <= stable_q[3:0];
            pulse_q  <= pulse_d;
        end
    end

    assign buttons       = pulse_q[2:0];
    assign start_trigger = pulse_q[3];
    assign switches      = stable_q[6:4];
    assign buttons_level = stable_q[2:0];

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus for input_conditioner with
// DEBOUNCE_CYCLES = 4 and active-low keys. Expected press pulses are queued
// with the edge number at which they must appear, and a monitor pops them.
module tb_input_conditioner;

    localparam int D = 4;

    typedef struct {
        int         edgeNo;
        logic [3:0] val;
        string      name;
    } exp_t;

    logic       async_reset;
    logic       clk;
    logic [2:0] raw_buttons;
    logic       raw_start;
    logic [2:0] raw_switches;
    logic [2:0] buttons;
    logic       start_trigger;
    logic [2:0] switches;
    logic [2:0] buttons_level;

    int   edgeCnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t expQ[$];

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH(16),
        .ACTIVE_LOW_KEYS(1)
    ) dut (
        .async_reset(async_reset),
        .clk(clk),
        .raw_buttons(raw_buttons),
        .raw_start(raw_start),
        .raw_switches(raw_switches),
        .buttons(buttons),
        .start_trigger(start_trigger),
        .switches(switches),
        .buttons_level(buttons_level)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Rising-edge counter used to timestamp expected pulses
    always @(posedge clk) edgeCnt = edgeCnt + 1;

    // Monitor: every observed pulse must match the oldest expected one, on the right edge
    always @(negedge clk) begin
        logic [3:0] act;
        exp_t       e;
        act = {start_trigger, buttons};
        if (act != 4'b0000) begin
            checks = checks + 1;
            if (expQ.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_pulse: got %b at edge %0d, required none", act, edgeCnt);
            end else begin
                e = expQ.pop_front();
                if (act !== e.val || edgeCnt != e.edgeNo) begin
                    errors = errors + 1;
                    $display("[TB] FAIL %s: got %b at edge %0d, required %b at edge %0d",
                             e.name, act, edgeCnt, e.val, e.edgeNo);
                end
            end
        end else if (expQ.size() != 0 && expQ[0].edgeNo < edgeCnt) begin
            e = expQ.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s: no pulse by edge %0d, required %b at edge %0d",
                     e.name, edgeCnt, e.val, e.edgeNo);
        end
    end

    // Drive raw inputs on a falling edge, then let n falling edges pass
    task automatic applyStimulus(input logic [2:0] b, input logic s, input logic [2:0] sw, input int n);
        raw_buttons  = b;
        raw_start    = s;
        raw_switches = sw;
        repeat (n) @(negedge clk);
    endtask

    // Queue a pulse due D+2 edges after the next rising edge (the sampling edge)
    task automatic expectPulse(input logic [3:0] v, input string name);
        exp_t e;
        e.edgeNo = edgeCnt + 1 + D + 2;
        e.val    = v;
        e.name   = name;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        async_reset  = 1'b0;
        raw_buttons  = 3'b111;
        raw_start    = 1'b1;
        raw_switches = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("reset_buttons", buttons, 3'b000);
        checkOutput("reset_start", {2'b00, start_trigger}, 3'b000);
        checkOutput("reset_switches", switches, 3'b000);
        checkOutput("reset_level", buttons_level, 3'b000);
        async_reset = 1'b1;
        applyStimulus(3'b111, 1'b1, 3'b000, 10);

        // Single press of button 1, held, then released
        expectPulse(4'b0010, "press_b1");
        applyStimulus(3'b101, 1'b1, 3'b000, 20);
        checkOutput("level_b1_held", buttons_level, 3'b010);
        applyStimulus(3'b111, 1'b1, 3'b000, 10);
        checkOutput("level_b1_released", buttons_level, 3'b000);

        // Bouncing button 0: 3 low / 1 high five times, then a steady press
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b110, 1'b1, 3'b000, 3);
            applyStimulus(3'b111, 1'b1, 3'b000, 1);
        end
        checkOutput("bounce_no_accept", buttons_level, 3'b000);
        expectPulse(4'b0001, "bounce_b0");
        applyStimulus(3'b110, 1'b1, 3'b000, 15);
        applyStimulus(3'b111, 1'b1, 3'b000, 10);

        // Switches: a steady change is accepted on edge D+1, a short glitch is not
        applyStimulus(3'b111, 1'b1, 3'b101, 5);
        checkOutput("switch_before_accept", switches, 3'b000);
        applyStimulus(3'b111, 1'b1, 3'b101, 1);
        checkOutput("switch_accepted", switches, 3'b101);
        applyStimulus(3'b111, 1'b1, 3'b111, 2);
        checkOutput("switch_glitch_mid", switches, 3'b101);
        applyStimulus(3'b111, 1'b1, 3'b101, 10);
        checkOutput("switch_glitch_after", switches, 3'b101);

        // Buttons 2 and 0 pressed on the same edge
`ifdef INPUT_CONDITIONER_LOCKOUT_EN
        expectPulse(4'b0100, "simultaneous_b2_b0");
`else
        expectPulse(4'b0101, "simultaneous_b2_b0");
`endif
        applyStimulus(3'b010, 1'b1, 3'b101, 12);
        checkOutput("level_simultaneous", buttons_level, 3'b101);
        applyStimulus(3'b111, 1'b1, 3'b101, 10);

        // Start held through an asynchronous reset pulse
        applyStimulus(3'b111, 1'b0, 3'b101, 2);
        #2 async_reset = 1'b0;
        #1;
        checkOutput("midreset_switches", switches, 3'b000);
        checkOutput("midreset_start", {2'b00, start_trigger}, 3'b000);
        applyStimulus(3'b111, 1'b0, 3'b101, 3);
        checkOutput("midreset_level", buttons_level, 3'b000);
        async_reset = 1'b1;
        e.edgeNo = edgeCnt + D + 3;
        e.val    = 4'b1000;
        e.name   = "start_after_reset";
        expQ.push_back(e);
        applyStimulus(3'b111, 1'b0, 3'b101, 20);
        applyStimulus(3'b111, 1'b1, 3'b101, 10);

        // Long hold gives one pulse; a second press gives another
        expectPulse(4'b0100, "long_hold_b2");
        applyStimulus(3'b011, 1'b1, 3'b101, 1000);
        checkOutput("level_long_hold", buttons_level, 3'b100);
        applyStimulus(3'b111, 1'b1, 3'b101, 10);
        expectPulse(4'b0100, "repress_b2");
        applyStimulus(3'b011, 1'b1, 3'b101, 20);
        applyStimulus(3'b111, 1'b1, 3'b101, 10);

        checks = checks + 1;
        if (expQ.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL pending_pulses: got %0d outstanding, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
